// File: rtl/alu_issue_ctrl_pkg.sv
// rtl/alu_issue_ctrl_pkg.sv - shared ALU opcode constants and opcode legality check
package alu_issue_ctrl_pkg;

  localparam int ALU_OPW = 4;

  localparam logic [ALU_OPW-1:0] OP_ADD = 4'b1111;
  localparam logic [ALU_OPW-1:0] OP_SUB = 4'b1110;
  localparam logic [ALU_OPW-1:0] OP_AND = 4'b0111;
  localparam logic [ALU_OPW-1:0] OP_OR  = 4'b0110;
  localparam logic [ALU_OPW-1:0] OP_NOT = 4'b0100;

  // True for the opcodes the ALU actually implements
  function automatic logic op_legal(input logic [ALU_OPW-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT: op_legal = 1'b1;
      default:                               op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_fifo.sv
// rtl/alu_op_fifo.sv - synchronous in-order operation queue with full/empty flags
module alu_op_fifo #(
  parameter int DW    = 20,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty)
        rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage is not reset; only the pointers define which entries are live
  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - queues ALU operations, drives the enable-gated ALU, returns results
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ALU_OPW-1:0] in_opcode,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               alu_enable,
  output logic [ALU_OPW-1:0] alu_opcode,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  input  logic [WIDTH-1:0]   alu_out,
  input  logic               alu_cout,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [WIDTH-1:0]   res_data,
  output logic               res_cout,
  output logic               res_err
);

  localparam int DW   = ALU_OPW + 2*WIDTH;
  localparam int CNTW = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]         state;
  logic [CNTW-1:0]    cnt;
  logic               full;
  logic               empty;
  logic [DW-1:0]      head;
  logic [ALU_OPW-1:0] head_op;
  logic [WIDTH-1:0]   head_a;
  logic [WIDTH-1:0]   head_b;
  logic               issue_now;

  assign in_ready = !full;
  assign head_op  = head[DW-1 -: ALU_OPW];
  assign head_a   = head[2*WIDTH-1 -: WIDTH];
  assign head_b   = head[WIDTH-1:0];

  // Issue from IDLE, or back-to-back from HOLD on the edge the result is taken
  assign issue_now = !empty && ((state == ST_IDLE) || (state == ST_HOLD && res_ready));

  alu_op_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .din   ({in_opcode, in_a, in_b}),
    .pop   (issue_now),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // Issue FSM: IDLE -> WAIT (ALU enabled for ALU_LAT cycles) -> HOLD (result offered)
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      alu_enable <= 1'b0;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_cout   <= 1'b0;
      res_err    <= 1'b0;
    end else begin
      if (state == ST_WAIT) begin
        if (cnt == CNTW'(1)) begin
          res_data   <= alu_out;
          res_cout   <= alu_cout;
          res_err    <= 1'b0;
          res_valid  <= 1'b1;
          alu_enable <= 1'b0;
          state      <= ST_HOLD;
        end else begin
          cnt <= cnt - CNTW'(1);
        end
      end

      if (state == ST_HOLD && res_ready) begin
        res_valid <= 1'b0;
        state     <= ST_IDLE;
      end

      // Later assignments override the HOLD release above when a new op goes out
      if (issue_now) begin
        if (op_legal(head_op)) begin
          alu_opcode <= head_op;
          alu_a      <= head_a;
          alu_b      <= head_b;
          alu_enable <= 1'b1;
          cnt        <= CNTW'(ALU_LAT);
          state      <= ST_WAIT;
        end else begin
          res_data  <= '0;
          res_cout  <= 1'b0;
          res_err   <= 1'b1;
          res_valid <= 1'b1;
          state     <= ST_HOLD;
        end
      end
    end
  end

endmodule
